// File: rtl/mux_sel_arbiter_pkg.sv
// Purpose: shared state encoding and width helper for the mux select arbiter.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
// Contents: state_e (IDLE/GRANT/GAP, 2-bit), clog2() for select and hold counter widths.
package mux_sel_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_sel_arbiter_if.sv
// Purpose: request/grant bundle between requesters and the mux select arbiter.
// Latency: n/a (wires only).
// Backpressure: req is a level held until granted; done is a one-cycle release pulse.
// Ports: req/done (requester -> arbiter), gnt/sel/sel_valid/busy (arbiter -> requesters, mux).
interface mux_sel_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int SEL_W = mux_sel_arbiter_pkg::clog2(N_REQ)
);

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] done;
  logic [N_REQ-1:0] gnt;
  logic [SEL_W-1:0] sel;
  logic             sel_valid;
  logic             busy;

  // Requester side.
  modport master (
    output req,
    output done,
    input  gnt,
    input  sel,
    input  sel_valid,
    input  busy
  );

  // Arbiter side.
  modport slave (
    input  req,
    input  done,
    output gnt,
    output sel,
    output sel_valid,
    output busy
  );

endinterface

// File: rtl/mux_sel_arbiter_rr_pick.sv
// Purpose: round-robin pick, first set bit of req scanning upward from ptr with wrap.
// Latency: combinational.
// Backpressure: none; any=0 means no requester is asking.
// Ports: req (request levels), ptr (scan start) -> pick (index), any (|req).
module rr_pick
  import mux_sel_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int SEL_W = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] pick,
  output logic             any
);

  logic [SEL_W-1:0] idx;

  // Scan from the farthest offset down to offset 0 so the last hit,
  // i.e. the closest requester at or after ptr, wins. N_REQ is a power
  // of two, so the SEL_W-bit add wraps modulo N_REQ by itself.
  always_comb begin
    pick = '0;
    any  = 1'b0;
    idx  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = ptr + SEL_W'(i);
      if (req[idx]) begin
        pick = idx;
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Purpose: round-robin owner of a shared select mux; drives sel and a one-hot grant.
// Latency: req in IDLE -> gnt/sel after 1 edge; release -> 1 dead (GAP) cycle -> next grant.
// Backpressure: owner keeps gnt until done/req drop, or MAX_HOLD cycles while others wait.
// Ports: clk, rst_n (async, active-low), bus (slave: req, done in; gnt, sel, sel_valid, busy out).
module mux_sel_arbiter
  import mux_sel_arbiter_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 8,
  // Derived from N_REQ; leave at its default.
  parameter int SEL_W    = clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  mux_sel_arbiter_if.slave bus
);

  localparam int                HOLD_W   = clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   owner_q, owner_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;

  logic [SEL_W-1:0]   pick;
  logic               any_req;
  logic               owner_done;
  logic               owner_req;
  logic               others_req;
  logic               hold_expired;
  logic               release_now;

  rr_pick #(
    .N_REQ (N_REQ),
    .SEL_W (SEL_W)
  ) u_rr_pick (
    .req  (bus.req),
    .ptr  (ptr_q),
    .pick (pick),
    .any  (any_req)
  );

  // gnt_q is the owner's one-hot mask while in GRANT, so masking with it
  // isolates the owner's done/req bits and everyone else's requests.
  // Any combination of the three causes collapses into one release.
  assign owner_done   = |(bus.done & gnt_q);
  assign owner_req    = |(bus.req & gnt_q);
  assign others_req   = |(bus.req & ~gnt_q);
  assign hold_expired = (hold_cnt_q == HOLD_MAX) && others_req;
  assign release_now  = owner_done || !owner_req || hold_expired;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;

    case (state_q)
      // IDLE and GAP both start a new grant from the current ptr; GAP
      // already carries the rotated ptr written on release.
      ST_IDLE, ST_GAP: begin
        if (any_req) begin
          state_d     = ST_GRANT;
          owner_d     = pick;
          sel_d       = pick;
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          hold_cnt_d  = HOLD_W'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_GRANT: begin
        if (release_now) begin
          state_d = ST_GAP;
          gnt_d   = '0;
          // Rotate past the owner regardless of who else is waiting.
          ptr_d   = owner_q + SEL_W'(1);
        end else if (hold_cnt_q != HOLD_MAX) begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      gnt_q      <= '0;
      sel_q      <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
    end
  end

  // sel holds the last owner through GAP/IDLE; only sel_valid drops.
  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;
  assign bus.sel_valid = |gnt_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule
